// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared types and widths for the VRAM port arbiter.
//   owner_t     - which requester owns the VRAM port in a given cycle
//   VRAM_ADDR_W - VRAM word-address width (same as the BG address width)
//   VRAM_DATA_W - VRAM data width
package vram_arb_pkg;

  localparam int VRAM_ADDR_W = 17;
  localparam int VRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_BG   = 2'd1,
    OWN_OBJ  = 2'd2,
    OWN_CPU  = 2'd3
  } owner_t;

endpackage

// File: rtl/vram_cpu_wait_tracker.sv
// vram_cpu_wait_tracker: counts consecutive cycles in which the CPU asked
// for the VRAM port and did not get it. Once the count reaches
// CPU_WAIT_LIMIT, force_cpu tells the arbiter to put the CPU ahead of OBJ.
// Ports:
//   clock     in  system clock
//   rst_b     in  synchronous reset, active high
//   cpu_req   in  CPU request this cycle
//   cpu_gnt   in  CPU access issued this cycle
//   force_cpu out CPU has waited long enough to beat OBJ
// wait_cnt is kept as a named register so it can be probed directly.
module vram_cpu_wait_tracker #(
  parameter int CPU_WAIT_LIMIT = 8
) (
  input  logic clock,
  input  logic rst_b,
  input  logic cpu_req,
  input  logic cpu_gnt,
  output logic force_cpu
);

  localparam int CNT_W = $clog2(CPU_WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(CPU_WAIT_LIMIT);

  logic [CNT_W-1:0] wait_cnt;

  // The count only tracks an unbroken run of denied cycles: a grant or a
  // withdrawn request both restart it. It saturates so a BG-heavy stretch
  // cannot wrap it back below the limit.
  always_ff @(posedge clock) begin
    if (rst_b) begin
      wait_cnt <= '0;
    end else if (!cpu_req || cpu_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != LIMIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign force_cpu = cpu_req && (wait_cnt >= LIMIT);

endmodule

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares the single VRAM port between the BG fetch unit,
// the OBJ fetch unit and the CPU bus.
//
// Priority: BG (fixed slots, never stalled) > CPU when its wait count has
// hit CPU_WAIT_LIMIT > OBJ > CPU.
//
// Handshake: obj_req / cpu_req are held by the requester until the matching
// *_gnt; a cycle with req && gnt is the cycle the access is driven onto the
// VRAM port. Dropping req before a grant is allowed and issues nothing.
// bg_req has no grant: it is always served in the cycle it is raised.
// Read data returns exactly one cycle after issue, flagged by the *_valid
// output of the owner recorded at issue; the data buses all carry vram_rdata.
//
// Ports:
//   clock, rst_b                  clock and synchronous active-high reset
//   bg_req/bg_addr                BG fetch request and address
//   bg_data/bg_valid              BG read return
//   obj_req/obj_addr/obj_gnt      OBJ request, address, issue strobe
//   obj_data/obj_valid            OBJ read return
//   cpu_req/cpu_we/cpu_be/cpu_addr/cpu_wdata/cpu_gnt   CPU access
//   cpu_rdata/cpu_rvalid          CPU read return (reads only)
//   vram_addr/vram_we/vram_be/vram_wdata/vram_rdata    VRAM macro port
// Optional (VRAM_ARB_STATS_EN defined):
//   stat_clr                      clears all statistics counters
//   stat_bg_cnt/stat_obj_cnt/stat_cpu_cnt   grants per requester
//   stat_cpu_stall                cycles the CPU requested but was denied
module vram_port_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W         = VRAM_ADDR_W,
  parameter int DATA_W         = VRAM_DATA_W,
  parameter int CPU_WAIT_LIMIT = 8
) (
  input  logic              clock,
  input  logic              rst_b,
  input  logic              bg_req,
  input  logic [ADDR_W-1:0] bg_addr,
  output logic [DATA_W-1:0] bg_data,
  output logic              bg_valid,
  input  logic              obj_req,
  input  logic [ADDR_W-1:0] obj_addr,
  output logic              obj_gnt,
  output logic [DATA_W-1:0] obj_data,
  output logic              obj_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [1:0]        vram_be,
  output logic [DATA_W-1:0] vram_wdata,
  input  logic [DATA_W-1:0] vram_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [31:0]       stat_bg_cnt,
  output logic [31:0]       stat_obj_cnt,
  output logic [31:0]       stat_cpu_cnt,
  output logic [31:0]       stat_cpu_stall
`endif
);

  owner_t owner;
  owner_t rd_tag;
  logic   force_cpu;

  vram_cpu_wait_tracker #(
    .CPU_WAIT_LIMIT(CPU_WAIT_LIMIT)
  ) u_wait (
    .clock    (clock),
    .rst_b    (rst_b),
    .cpu_req  (cpu_req),
    .cpu_gnt  (cpu_gnt),
    .force_cpu(force_cpu)
  );

  // Owner for this cycle. force_cpu already includes cpu_req.
  always_comb begin
    owner = OWN_NONE;
    if (rst_b) begin
      owner = OWN_NONE;
    end else if (bg_req) begin
      owner = OWN_BG;
    end else if (force_cpu) begin
      owner = OWN_CPU;
    end else if (obj_req) begin
      owner = OWN_OBJ;
    end else if (cpu_req) begin
      owner = OWN_CPU;
    end
  end

  assign obj_gnt = (owner == OWN_OBJ);
  assign cpu_gnt = (owner == OWN_CPU);

  // VRAM port mux. Reads always fetch the full word.
  always_comb begin
    vram_addr = '0;
    vram_we   = 1'b0;
    vram_be   = 2'b11;
    case (owner)
      OWN_BG:  vram_addr = bg_addr;
      OWN_OBJ: vram_addr = obj_addr;
      OWN_CPU: begin
        vram_addr = cpu_addr;
        vram_we   = cpu_we;
        vram_be   = cpu_we ? cpu_be : 2'b11;
      end
      default: vram_addr = '0;
    endcase
  end

  assign vram_wdata = cpu_wdata;

  // Owner of the data arriving next cycle. CPU writes return nothing, so
  // they are recorded as NONE.
  always_ff @(posedge clock) begin
    if (rst_b) begin
      rd_tag <= OWN_NONE;
    end else if (owner == OWN_CPU && cpu_we) begin
      rd_tag <= OWN_NONE;
    end else begin
      rd_tag <= owner;
    end
  end

  // Valids are also masked while reset is held, so a read issued just
  // before reset never reports data regardless of where reset lands.
  assign bg_valid   = !rst_b && (rd_tag == OWN_BG);
  assign obj_valid  = !rst_b && (rd_tag == OWN_OBJ);
  assign cpu_rvalid = !rst_b && (rd_tag == OWN_CPU);

  assign bg_data   = vram_rdata;
  assign obj_data  = vram_rdata;
  assign cpu_rdata = vram_rdata;

`ifdef VRAM_ARB_STATS_EN
  // Free-running 32-bit counters; clear beats a same-cycle increment.
  always_ff @(posedge clock) begin
    if (rst_b || stat_clr) begin
      stat_bg_cnt    <= '0;
      stat_obj_cnt   <= '0;
      stat_cpu_cnt   <= '0;
      stat_cpu_stall <= '0;
    end else begin
      if (owner == OWN_BG)  stat_bg_cnt  <= stat_bg_cnt + 32'd1;
      if (owner == OWN_OBJ) stat_obj_cnt <= stat_obj_cnt + 32'd1;
      if (owner == OWN_CPU) stat_cpu_cnt <= stat_cpu_cnt + 32'd1;
      if (cpu_req && !cpu_gnt) stat_cpu_stall <= stat_cpu_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Testbench for vram_port_arbiter. A reference process predicts the owner
// each cycle, checks the port mux and grants, and queues the expected read
// return for the following cycle; scenario tasks add targeted checks.
module tb_vram_port_arbiter;
  import vram_arb_pkg::*;

  localparam int AW    = 17;
  localparam int DW    = 16;
  localparam int LIMIT = 8;
  localparam int SB_W  = 16 + 3 + DW;

  logic          clock;
  logic          rst_b;
  logic          bg_req;
  logic [AW-1:0] bg_addr;
  logic [DW-1:0] bg_data;
  logic          bg_valid;
  logic          obj_req;
  logic [AW-1:0] obj_addr;
  logic          obj_gnt;
  logic [DW-1:0] obj_data;
  logic          obj_valid;
  logic          cpu_req;
  logic          cpu_we;
  logic [1:0]    cpu_be;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic [AW-1:0] vram_addr;
  logic          vram_we;
  logic [1:0]    vram_be;
  logic [DW-1:0] vram_wdata;
  logic [DW-1:0] vram_rdata;
`ifdef VRAM_ARB_STATS_EN
  logic          stat_clr;
  logic [31:0]   stat_bg_cnt;
  logic [31:0]   stat_obj_cnt;
  logic [31:0]   stat_cpu_cnt;
  logic [31:0]   stat_cpu_stall;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int mw = 0;
  logic [SB_W-1:0] exp_q[$];

  vram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .CPU_WAIT_LIMIT(LIMIT)
  ) dut (
    .clock(clock), .rst_b(rst_b),
    .bg_req(bg_req), .bg_addr(bg_addr), .bg_data(bg_data), .bg_valid(bg_valid),
    .obj_req(obj_req), .obj_addr(obj_addr), .obj_gnt(obj_gnt),
    .obj_data(obj_data), .obj_valid(obj_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_be(vram_be),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
`ifdef VRAM_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_bg_cnt(stat_bg_cnt), .stat_obj_cnt(stat_obj_cnt),
    .stat_cpu_cnt(stat_cpu_cnt), .stat_cpu_stall(stat_cpu_stall)
`endif
  );

  // ---------------- clock / reset / environment ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h5AA5 ^ {a[16], 15'h0};
  endfunction

  // VRAM macro: fixed address-derived contents, 1-cycle read latency.
  always @(posedge clock) vram_rdata <= mem_f(vram_addr);

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1, "timeout");
  end

  // ---------------- reference model + scoreboard ----------------
  always @(negedge clock) begin : scoreboard
    owner_t          eo;
    logic [AW-1:0]   ea;
    logic [2:0]      ev;
    logic [2:0]      gv;
    logic [1:0]      ebe;
    logic [SB_W-1:0] ent;
    if (rst_b)                             eo = OWN_NONE;
    else if (bg_req)                       eo = OWN_BG;
    else if (cpu_req && mw >= LIMIT)       eo = OWN_CPU;
    else if (obj_req)                      eo = OWN_OBJ;
    else if (cpu_req)                      eo = OWN_CPU;
    else                                   eo = OWN_NONE;
    case (eo)
      OWN_BG:  ea = bg_addr;
      OWN_OBJ: ea = obj_addr;
      OWN_CPU: ea = cpu_addr;
      default: ea = '0;
    endcase

    vectors++;
    if ({obj_gnt, cpu_gnt} !== {eo == OWN_OBJ, eo == OWN_CPU}) begin
      miscompares++;
      $display("FAIL sb_grant cyc=%0d obj/cpu gnt got %b%b want %b%b",
               cyc, obj_gnt, cpu_gnt, eo == OWN_OBJ, eo == OWN_CPU);
    end
    vectors++;
    if (vram_addr !== ea || vram_we !== (eo == OWN_CPU && cpu_we)) begin
      miscompares++;
      $display("FAIL sb_port cyc=%0d addr/we got %h/%b want %h/%b",
               cyc, vram_addr, vram_we, ea, eo == OWN_CPU && cpu_we);
    end
    if (eo != OWN_NONE) begin
      ebe = (eo == OWN_CPU && cpu_we) ? cpu_be : 2'b11;
      vectors++;
      if (vram_be !== ebe) begin
        miscompares++;
        $display("FAIL sb_be cyc=%0d got %b want %b", cyc, vram_be, ebe);
      end
    end
    vectors++;
    if (int'(dut.u_wait.wait_cnt) !== mw) begin
      miscompares++;
      $display("FAIL sb_wait_cnt cyc=%0d got %0d want %0d", cyc, dut.u_wait.wait_cnt, mw);
    end

    // Read returns due this cycle.
    while (exp_q.size() > 0 && exp_q[0][SB_W-1 -: 16] <= 16'(cyc)) begin
      ent = exp_q.pop_front();
      ev  = rst_b ? 3'b000 : ent[DW+2:DW];
      gv  = {bg_valid, obj_valid, cpu_rvalid};
      vectors++;
      if (ent[SB_W-1 -: 16] != 16'(cyc) || gv !== ev) begin
        miscompares++;
        $display("FAIL sb_valid cyc=%0d bg/obj/cpu valid got %b want %b", cyc, gv, ev);
      end else if (ev != 3'b000 &&
                   (bg_data !== ent[DW-1:0] || obj_data !== ent[DW-1:0] ||
                    cpu_rdata !== ent[DW-1:0])) begin
        miscompares++;
        $display("FAIL sb_data cyc=%0d bg/obj/cpu data got %h/%h/%h want %h",
                 cyc, bg_data, obj_data, cpu_rdata, ent[DW-1:0]);
      end
    end

    if (rst_b) ev = 3'b000;
    else       ev = {eo == OWN_BG, eo == OWN_OBJ, eo == OWN_CPU && !cpu_we};
    exp_q.push_back({16'(cyc + 1), ev, mem_f(ea)});

    if (rst_b)                        mw = 0;
    else if (cpu_req && eo != OWN_CPU) mw = (mw < LIMIT) ? mw + 1 : mw;
    else                              mw = 0;
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bg_req    = 1'b0;
    bg_addr   = '0;
    obj_req   = 1'b0;
    obj_addr  = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_be    = 2'b00;
    cpu_addr  = '0;
    cpu_wdata = '0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return AW'($urandom_range(0, (1 << AW) - 1));
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_b = 1'b1;
    idle();
    bg_req = 1'b1; obj_req = 1'b1; cpu_req = 1'b1;
    repeat (2) next_cycle();
    @(negedge clock);
    vectors++;
    if ({obj_gnt, cpu_gnt, bg_valid, obj_valid, cpu_rvalid} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b want 00000",
               {obj_gnt, cpu_gnt, bg_valid, obj_valid, cpu_rvalid});
    end
    vectors++;
    if (dut.u_wait.wait_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_wait_cnt got %0d want 0", dut.u_wait.wait_cnt);
    end
    next_cycle();
    rst_b = 1'b0;
    idle();
    next_cycle();
  endtask

  task automatic test_bg_priority();
    for (int i = 0; i < 20; i++) begin
      bg_req = 1'b1;  bg_addr  = rand_addr();
      obj_req = 1'b1; obj_addr = rand_addr();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = rand_addr();
      @(negedge clock);
      vectors++;
      if (obj_gnt !== 1'b0 || cpu_gnt !== 1'b0) begin
        miscompares++;
        $display("FAIL bg_priority_gnt i=%0d obj/cpu got %b%b want 00", i, obj_gnt, cpu_gnt);
      end
      if (i > 0) begin
        vectors++;
        if (bg_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL bg_priority_valid i=%0d got %b want 1", i, bg_valid);
        end
      end
      if (i == 19) begin
        vectors++;
        if (int'(dut.u_wait.wait_cnt) !== LIMIT) begin
          miscompares++;
          $display("FAIL bg_wait_saturate got %0d want %0d", dut.u_wait.wait_cnt, LIMIT);
        end
      end
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  task automatic test_cpu_starvation();
    logic [AW-1:0] ca;
    ca = 17'h01234;
    for (int i = 0; i < 10; i++) begin
      obj_req = 1'b1; obj_addr = rand_addr();
      cpu_req = (i <= 8); cpu_we = 1'b0; cpu_addr = ca;
      @(negedge clock);
      vectors++;
      if (obj_gnt !== (i != 8) || cpu_gnt !== (i == 8)) begin
        miscompares++;
        $display("FAIL starvation_gnt i=%0d obj/cpu got %b%b want %b%b",
                 i, obj_gnt, cpu_gnt, i != 8, i == 8);
      end
      if (i == 9) begin
        vectors++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== mem_f(ca)) begin
          miscompares++;
          $display("FAIL starvation_rdata got %b/%h want 1/%h", cpu_rvalid, cpu_rdata, mem_f(ca));
        end
      end
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  task automatic test_cpu_write();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b01;
    cpu_addr = 17'h00010; cpu_wdata = 16'hABCD;
    @(negedge clock);
    vectors++;
    if ({cpu_gnt, vram_we, vram_be, vram_addr, vram_wdata} !==
        {1'b1, 1'b1, 2'b01, 17'h00010, 16'hABCD}) begin
      miscompares++;
      $display("FAIL cpu_write_port got gnt=%b we=%b be=%b addr=%h wd=%h want 1 1 01 00010 abcd",
               cpu_gnt, vram_we, vram_be, vram_addr, vram_wdata);
    end
    next_cycle();
    idle();
    @(negedge clock);
    vectors++;
    if (cpu_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL cpu_write_rvalid got %b want 0", cpu_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_alternating();
    for (int i = 0; i < 12; i++) begin
      bg_req = (i % 2 == 0); bg_addr = rand_addr();
      obj_req = 1'b1; obj_addr = rand_addr();
      @(negedge clock);
      vectors++;
      if (obj_gnt !== (i % 2 == 1)) begin
        miscompares++;
        $display("FAIL alt_obj_gnt i=%0d got %b want %b", i, obj_gnt, i % 2 == 1);
      end
      if (i > 0) begin
        vectors++;
        if (obj_valid !== (i % 2 == 0) || bg_valid !== (i % 2 == 1) ||
            (bg_valid && obj_valid)) begin
          miscompares++;
          $display("FAIL alt_valid i=%0d bg/obj got %b%b want %b%b",
                   i, bg_valid, obj_valid, i % 2 == 1, i % 2 == 0);
        end
      end
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = rand_addr();
    @(negedge clock);
    vectors++;
    if (cpu_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL midread_issue got %b want 1", cpu_gnt);
    end
    next_cycle();
    rst_b = 1'b1;
    idle();
    bg_req = 1'b1; obj_req = 1'b1; cpu_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      vectors++;
      if ({cpu_rvalid, obj_gnt, cpu_gnt} !== 3'b000) begin
        miscompares++;
        $display("FAIL midread_reset i=%0d rvalid/obj/cpu got %b want 000",
                 i, {cpu_rvalid, obj_gnt, cpu_gnt});
      end
      next_cycle();
    end
    rst_b = 1'b0;
    idle();
    @(negedge clock);
    vectors++;
    if (cpu_rvalid !== 1'b0 || dut.u_wait.wait_cnt !== '0) begin
      miscompares++;
      $display("FAIL midread_after got rvalid=%b wait=%0d want 0 0", cpu_rvalid, dut.u_wait.wait_cnt);
    end
    next_cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      bg_req    = ($urandom_range(0, 3) == 0);
      bg_addr   = rand_addr();
      obj_req   = ($urandom_range(0, 1) == 1);
      obj_addr  = rand_addr();
      cpu_req   = ($urandom_range(0, 2) != 0);
      cpu_we    = ($urandom_range(0, 1) == 1);
      cpu_be    = 2'($urandom_range(0, 3));
      cpu_addr  = rand_addr();
      cpu_wdata = DW'($urandom_range(0, 65535));
      @(negedge clock);
      vectors++;
      if (obj_gnt && cpu_gnt) begin
        miscompares++;
        $display("FAIL random_onehot i=%0d obj/cpu got 11 want not both", i);
      end
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

`ifdef VRAM_ARB_STATS_EN
  task automatic test_stats();
    stat_clr = 1'b1;
    next_cycle();
    stat_clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle();
      bg_req  = (i < 4) || (i == 5);
      obj_req = (i >= 6 && i <= 8);
      cpu_req = (i <= 4) || (i == 9);
      bg_addr = rand_addr(); obj_addr = rand_addr(); cpu_addr = rand_addr();
      next_cycle();
    end
    idle();
    @(negedge clock);
    vectors++;
    if ({stat_bg_cnt, stat_obj_cnt, stat_cpu_cnt, stat_cpu_stall} !==
        {32'd5, 32'd3, 32'd2, 32'd4}) begin
      miscompares++;
      $display("FAIL stats_count got %0d/%0d/%0d/%0d want 5/3/2/4",
               stat_bg_cnt, stat_obj_cnt, stat_cpu_cnt, stat_cpu_stall);
    end
    next_cycle();
    stat_clr = 1'b1;
    bg_req = 1'b1;
    next_cycle();
    stat_clr = 1'b0;
    idle();
    @(negedge clock);
    vectors++;
    if ({stat_bg_cnt, stat_obj_cnt, stat_cpu_cnt, stat_cpu_stall} !== 128'd0) begin
      miscompares++;
      $display("FAIL stats_clear got %0d/%0d/%0d/%0d want 0/0/0/0",
               stat_bg_cnt, stat_obj_cnt, stat_cpu_cnt, stat_cpu_stall);
    end
    next_cycle();
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    rst_b = 1'b1;
    idle();
`ifdef VRAM_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    test_reset();
    test_bg_priority();
    test_cpu_starvation();
    test_cpu_write();
    test_alternating();
    test_reset_mid_read();
    test_random();
`ifdef VRAM_ARB_STATS_EN
    test_stats();
`endif
    repeat (2) next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
